loop_sequencer: RTL and testbench

//  Program sequencer for the core: drives the instruction-cache PC and decodes the two control

---
 rtl/loop_sequencer.sv | 226 ++++++++++++++++++++++
 tb/tb_loop_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/loop_sequencer.sv
// rtl/loop_sequencer.sv - program sequencer with hardware loop stack and issue handshake
// Purpose: drives the icache PC, executes start_loop (4'hD) and end_loop_or_jump (4'hC)
//          against a hardware loop stack, and offers every other instruction downstream.
// Ports:   clk, reset (sync, active-high), start/start_pc (launch from IDLE or DONE),
//          prog_loop_ro_data (NLOOPS x 24 b descriptors, entry0 at the top),
//          pc (fetch address), raw_instruction (fetched word, same cycle),
//          instr_valid/instr/instr_ready (issue handshake), loop_vars (iter per level,
//          level 0 in [15:0]), loop_level (stack occupancy), busy, done, error,
//          issue_count (handshake counter).
// Option:  LOOP_SEQ_PERF_EN enables the saturating issue counter; otherwise issue_count is 0.
module loop_sequencer #(
   parameter int DEPTH  = 4,
   parameter int NLOOPS = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [15:0]                start_pc,
   input  logic [24*NLOOPS-1:0]       prog_loop_ro_data,
   output logic [15:0]                pc,
   input  logic [15:0]                raw_instruction,
   output logic                       instr_valid,
   output logic [15:0]                instr,
   input  logic                       instr_ready,
   output logic [16*DEPTH-1:0]        loop_vars,
   output logic [$clog2(DEPTH+1)-1:0] loop_level,
   output logic                       busy,
   output logic                       done,
   output logic                       error,
   output logic [31:0]                issue_count
);

   localparam int         LVL_W    = $clog2(DEPTH+1);
   localparam logic [3:0] OP_START = 4'hD;
   localparam logic [3:0] OP_END   = 4'hC;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [15:0]      r_pc;
   logic [LVL_W-1:0] r_sp;
   logic             r_error;
   logic [15:0]      r_body_pc [DEPTH];
   logic [11:0]      r_n       [DEPTH];
   logic [11:0]      r_iter    [DEPTH];

   logic [3:0]       w_opcode;
   logic [LVL_W-1:0] w_top;
   logic [15:0]      w_top_pc;
   logic [11:0]      w_top_n;
   logic [11:0]      w_top_iter;
   logic [12:0]      w_iter_inc;
   logic [11:0]      w_desc_n;
   logic [15:0]      w_pc_inc;
   logic [15:0]      w_pc_next;
   logic             w_stack_full;
   logic             w_start_ok;
   logic             w_push;
   logic             w_pop;
   logic             w_branch;
   logic             w_overflow;
   logic             w_unused_desc;

   assign w_opcode     = raw_instruction[15:12];
   assign w_pc_inc     = r_pc + 16'd1;
   assign w_stack_full = (r_sp == LVL_W'(DEPTH));
   assign w_top        = r_sp - LVL_W'(1);
   assign w_iter_inc   = {1'b0, w_top_iter} + 13'd1;

   // Descriptor low fields are reserved; fold them so they are visibly consumed.
   assign w_unused_desc = ^prog_loop_ro_data;

   // Iteration count of the addressed descriptor; out-of-range index and N=0 both mean 1.
   always_comb begin
      w_desc_n = 12'd1;
      for (int i = 0; i < NLOOPS && i < 8; i++) begin
         if (raw_instruction[2:0] == 3'(i))
            w_desc_n = prog_loop_ro_data[24*NLOOPS-1-24*i -: 12];
      end
      if (w_desc_n == 12'd0)
         w_desc_n = 12'd1;
   end

   // Top-of-stack view, selected by compare so the index width never matters.
   always_comb begin
      w_top_pc   = '0;
      w_top_n    = '0;
      w_top_iter = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (w_top == LVL_W'(k)) begin
            w_top_pc   = r_body_pc[k];
            w_top_n    = r_n[k];
            w_top_iter = r_iter[k];
         end
      end
   end

   // Next state and per-cycle decision.
   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      instr_valid  = 1'b0;
      w_start_ok   = 1'b0;
      w_push       = 1'b0;
      w_pop        = 1'b0;
      w_branch     = 1'b0;
      w_overflow   = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_start_ok   = 1'b1;
               w_state_next = S_RUN;
               w_pc_next    = start_pc;
            end
         end
         S_RUN: begin
            case (w_opcode)
               OP_START: begin
                  if (w_stack_full) begin
                     w_overflow   = 1'b1;
                     w_state_next = S_DONE;
                  end else begin
                     w_push    = 1'b1;
                     w_pc_next = w_pc_inc;
                  end
               end
               OP_END: begin
                  if (r_sp == '0) begin
                     w_state_next = S_DONE;
                  end else if (w_iter_inc < {1'b0, w_top_n}) begin
                     w_branch  = 1'b1;
                     w_pc_next = w_top_pc;
                  end else begin
                     w_pop     = 1'b1;
                     w_pc_next = w_pc_inc;
                  end
               end
               default: begin
                  instr_valid = 1'b1;
                  if (instr_ready)
                     w_pc_next = w_pc_inc;
               end
            endcase
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_pc    <= '0;
         r_sp    <= '0;
         r_error <= 1'b0;
         for (int k = 0; k < DEPTH; k++) begin
            r_body_pc[k] <= '0;
            r_n[k]       <= '0;
            r_iter[k]    <= '0;
         end
      end else begin
         r_state <= w_state_next;
         r_pc    <= w_pc_next;
         if (w_start_ok) begin
            r_sp    <= '0;
            r_error <= 1'b0;
         end
         if (w_overflow)
            r_error <= 1'b1;
         if (w_push)
            r_sp <= r_sp + LVL_W'(1);
         if (w_pop)
            r_sp <= w_top;
         for (int k = 0; k < DEPTH; k++) begin
            if (w_start_ok)
               r_iter[k] <= '0;
            if (w_push && r_sp == LVL_W'(k)) begin
               r_body_pc[k] <= w_pc_inc;
               r_n[k]       <= w_desc_n;
               r_iter[k]    <= '0;
            end
            if (w_branch && w_top == LVL_W'(k))
               r_iter[k] <= w_iter_inc[11:0];
            // Popped level reads 0 from here on.
            if (w_pop && w_top == LVL_W'(k))
               r_iter[k] <= '0;
         end
      end
   end

   always_comb begin
      loop_vars = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (LVL_W'(k) < r_sp)
            loop_vars[16*k +: 16] = {4'd0, r_iter[k]};
      end
   end

   assign pc         = r_pc;
   assign instr      = raw_instruction;
   assign loop_level = r_sp;
   assign busy       = (r_state == S_RUN);
   assign done       = (r_state == S_DONE) && !r_error;
   assign error      = r_error;

`ifdef LOOP_SEQ_PERF_EN
   logic        w_fire;
   logic [31:0] r_issue_count;

   assign w_fire = instr_valid && instr_ready;

   always_ff @(posedge clk) begin
      if (reset)
         r_issue_count <= '0;
      else if (w_start_ok)
         r_issue_count <= '0;
      else if (w_fire && r_issue_count != 32'hFFFF_FFFF)
         r_issue_count <= r_issue_count + 32'd1;
   end

   assign issue_count = r_issue_count;
`else
   assign issue_count = 32'd0;
`endif

endmodule

// File: tb/tb_loop_sequencer.sv
// tb/tb_loop_sequencer.sv - self-checking bench for loop_sequencer
module tb_loop_sequencer;
   localparam int DEPTH  = 4;
   localparam int NLOOPS = 8;
   localparam int BUDGET = 20000;

   logic                       clk = 1'b0;
   logic                       reset = 1'b1;
   logic                       start = 1'b0;
   logic [15:0]                start_pc = '0;
   logic [24*NLOOPS-1:0]       prog_loop_ro_data;
   logic [15:0]                pc;
   logic [15:0]                raw_instruction;
   logic                       instr_valid;
   logic [15:0]                instr;
   logic                       instr_ready = 1'b0;
   logic [16*DEPTH-1:0]        loop_vars;
   logic [$clog2(DEPTH+1)-1:0] loop_level;
   logic                       busy, done, error;
   logic [31:0]                issue_count;

   logic [15:0] mem  [0:255];
   logic [23:0] desc [NLOOPS];

   int total = 0;
   int bad   = 0;

   logic [15:0] exp_pc[$];
   logic [15:0] exp_instr[$];
   logic [63:0] exp_lv[$];
   logic [15:0] exp_end_pc;
   logic        exp_err;
   int          exp_maxlvl;
   int          exp_end_lvl;

   loop_sequencer #(.DEPTH(DEPTH), .NLOOPS(NLOOPS)) dut (
      .clk(clk), .reset(reset), .start(start), .start_pc(start_pc),
      .prog_loop_ro_data(prog_loop_ro_data), .pc(pc), .raw_instruction(raw_instruction),
      .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
      .loop_vars(loop_vars), .loop_level(loop_level), .busy(busy), .done(done),
      .error(error), .issue_count(issue_count)
   );

   always #5 clk = ~clk;

   assign raw_instruction = mem[pc[7:0]];

   always_comb begin
      for (int i = 0; i < NLOOPS; i++)
         prog_loop_ro_data[24*NLOOPS-1-24*i -: 24] = desc[i];
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_prog();
      for (int i = 0; i < 256; i++) mem[i] = 16'hC000;
      for (int i = 0; i < NLOOPS; i++) desc[i] = 24'h001000;
   endtask

   // Interpreter of the program: what must be issued, in which order, with which loop indices.
   task automatic model(input logic [15:0] spc);
      logic [15:0] p, ins;
      logic [15:0] bpc[$];
      int          n[$];
      int          it[$];
      logic [63:0] lv;
      int          nn;
      exp_pc.delete(); exp_instr.delete(); exp_lv.delete();
      exp_err = 1'b0; exp_maxlvl = 0; p = spc;
      for (int s = 0; s < BUDGET; s++) begin
         ins = mem[p[7:0]];
         if (ins[15:12] == 4'hD) begin
            if (n.size() == DEPTH) begin exp_err = 1'b1; break; end
            nn = (int'(ins[2:0]) < NLOOPS) ? int'(desc[ins[2:0]][23:12]) : 1;
            if (nn == 0) nn = 1;
            bpc.push_back(p + 16'd1); n.push_back(nn); it.push_back(0);
            if (n.size() > exp_maxlvl) exp_maxlvl = n.size();
            p = p + 16'd1;
         end else if (ins[15:12] == 4'hC) begin
            if (n.size() == 0) break;
            if (it[it.size()-1] + 1 < n[n.size()-1]) begin
               it[it.size()-1] = it[it.size()-1] + 1;
               p = bpc[bpc.size()-1];
            end else begin
               void'(bpc.pop_back()); void'(n.pop_back()); void'(it.pop_back());
               p = p + 16'd1;
            end
         end else begin
            lv = '0;
            for (int k = 0; k < it.size(); k++) lv[16*k +: 16] = 16'(it[k]);
            exp_pc.push_back(p); exp_instr.push_back(ins); exp_lv.push_back(lv);
            p = p + 16'd1;
         end
      end
      exp_end_pc = p; exp_end_lvl = n.size();
   endtask

   // rmode: 0 ready high, 1 ready toggling, 2 ready random. abort_after>=0 returns mid-run.
   task automatic run(input logic [15:0] spc, input int rmode, input string tag, input int abort_after);
      int          cyc, got, maxl;
      logic        prev_stall;
      logic [15:0] prev_pc, prev_instr;
      model(spc);
      @(negedge clk); start_pc = spc; start = 1'b1;
      @(negedge clk); start = 1'b0;
      cyc = 0; got = 0; maxl = 0; prev_stall = 1'b0; prev_pc = '0; prev_instr = '0;
      while (1) begin
         case (rmode)
            0:       instr_ready = 1'b1;
            1:       instr_ready = (cyc % 2 == 0);
            default: instr_ready = 1'($urandom_range(0, 1));
         endcase
         #1;
         if (int'(loop_level) > maxl) maxl = int'(loop_level);
         if (!busy) break;
         if (prev_stall) check({tag, "_stall_hold"}, {32'd0, pc, instr}, {32'd0, prev_pc, prev_instr});
         if (instr_valid && instr_ready) begin
            if (got < exp_pc.size()) begin
               check({tag, "_pc"}, 64'(pc), 64'(exp_pc[got]));
               check({tag, "_instr"}, 64'(instr), 64'(exp_instr[got]));
               check({tag, "_loop_vars"}, loop_vars, exp_lv[got]);
            end else begin
               check({tag, "_extra_issue"}, 64'(got), 64'(exp_pc.size()));
            end
            got++;
            if (abort_after >= 0 && got == abort_after) return;
         end
         prev_stall = instr_valid && !instr_ready;
         prev_pc = pc; prev_instr = instr;
         cyc++;
         if (cyc > BUDGET) begin
            check({tag, "_timeout"}, 64'(cyc), 64'(BUDGET));
            break;
         end
         @(negedge clk);
      end
      check({tag, "_issues"}, 64'(got), 64'(exp_pc.size()));
      check({tag, "_end_pc"}, 64'(pc), 64'(exp_end_pc));
      check({tag, "_error"}, 64'(error), 64'(exp_err));
      check({tag, "_done"}, 64'(done), 64'(!exp_err));
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_max_level"}, 64'(maxl), 64'(exp_maxlvl));
      check({tag, "_end_level"}, 64'(loop_level), 64'(exp_end_lvl));
`ifdef LOOP_SEQ_PERF_EN
      check({tag, "_issue_count"}, 64'(issue_count), 64'(exp_pc.size()));
`else
      check({tag, "_issue_count"}, 64'(issue_count), 64'd0);
`endif
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_error"}, 64'(error), 64'd0);
      check({tag, "_pc"}, 64'(pc), 64'd0);
      check({tag, "_level"}, 64'(loop_level), 64'd0);
      check({tag, "_loop_vars"}, loop_vars, 64'd0);
      check({tag, "_valid"}, 64'(instr_valid), 64'd0);
      check({tag, "_issue_count"}, 64'(issue_count), 64'd0);
   endtask

   task automatic gen_random(input logic [15:0] spc);
      logic [15:0] p;
      int          open, r, op;
      clear_prog();
      for (int i = 0; i < NLOOPS; i++) desc[i] = {12'($urandom_range(0, 3)), 12'($urandom)};
      p = spc; open = 0;
      for (int s = 0; s < 30; s++) begin
         r = $urandom_range(0, 9);
         if (r < 2 && open < 3) begin
            mem[p[7:0]] = {4'hD, 9'($urandom), 3'($urandom_range(0, 7))}; open++;
         end else if (r < 4 && open > 0) begin
            mem[p[7:0]] = {4'hC, 12'($urandom)}; open--;
         end else begin
            op = $urandom_range(0, 13);
            if (op >= 12) op = op + 2;
            mem[p[7:0]] = {4'(op), 12'($urandom)};
         end
         p = p + 16'd1;
      end
      for (int s = 0; s < open; s++) begin mem[p[7:0]] = 16'hC000; p = p + 16'd1; end
      mem[p[7:0]] = 16'hC000;
   endtask

   task automatic load_prog1();
      clear_prog();
      mem[6] = 16'hD000; mem[7] = 16'h4080; mem[8] = 16'h2000; mem[9] = 16'h8000;
      mem[10] = 16'h0180; mem[11] = 16'h6120; mem[12] = 16'hC000; mem[13] = 16'hC000;
      desc[0] = 24'h004006;
   endtask

   initial begin
      clear_prog();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check_reset_state("reset");
      reset = 1'b0;

      load_prog1();
      run(16'd6, 0, "t1_basic", -1);
      run(16'd6, 1, "t2_toggle", -1);

      clear_prog();
      mem[20] = 16'hD000; mem[21] = 16'hD001; mem[22] = 16'h3456;
      mem[23] = 16'hC000; mem[24] = 16'hC000; mem[25] = 16'hC000;
      desc[0] = 24'h002000; desc[1] = 24'h003000;
      run(16'd20, 0, "t3_nested", -1);

      clear_prog();
      for (int i = 0; i < 5; i++) mem[40+i] = 16'hD000 | 16'(i);
      run(16'd40, 1, "t4_overflow", -1);

      clear_prog();
      mem[50] = 16'hD002; mem[51] = 16'h1234; mem[52] = 16'hC000; mem[53] = 16'hC000;
      desc[2] = 24'h000FFF;
      run(16'd50, 0, "t5_n_zero", -1);
      clear_prog();
      run(16'd60, 0, "t5_bare_halt", -1);

      load_prog1();
      run(16'd6, 0, "t6_abort", 7);
      reset = 1'b1;
      @(negedge clk); #1;
      check_reset_state("t6_after_reset");
      reset = 1'b0;
      run(16'd6, 0, "t6_restart", -1);

      gen_random(16'hFFF0);
      run(16'hFFF0, 2, "rnd_wrap", -1);
      for (int t = 0; t < 4; t++) begin
         start_pc = 16'($urandom_range(0, 200));
         gen_random(start_pc);
         run(start_pc, 2, "rnd", -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
